// File: rtl/reservation_station.sv
// Collapsing issue queue: holds renamed instructions until both operands arrive,
// then issues the oldest ready entry. Index 0 is always the oldest.
module reservation_station #(
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [PAYLOAD_W-1:0]           dispatch_payload,
    input  logic [TAG_W-1:0]               dispatch_rd,
    input  logic [TAG_W-1:0]               dispatch_rs1,
    input  logic                           dispatch_rs1_ready,
    input  logic [DATA_W-1:0]              dispatch_rs1_value,
    input  logic [TAG_W-1:0]               dispatch_rs2,
    input  logic                           dispatch_rs2_ready,
    input  logic [DATA_W-1:0]              dispatch_rs2_value,
    input  logic                           wakeup_active,
    input  logic [TAG_W-1:0]               wakeup_tag,
    input  logic [DATA_W-1:0]              wakeup_value,
    output logic                           issue_valid,
    input  logic                           issue_accept,
    output logic [PAYLOAD_W-1:0]           issue_payload,
    output logic [TAG_W-1:0]               issue_rd,
    output logic [DATA_W-1:0]              issue_rs1_value,
    output logic [DATA_W-1:0]              issue_rs2_value,
    output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     rd;
        logic [TAG_W-1:0]     rs1_tag;
        logic                 rs1_rdy;
        logic [DATA_W-1:0]    rs1_val;
        logic [TAG_W-1:0]     rs2_tag;
        logic                 rs2_rdy;
        logic [DATA_W-1:0]    rs2_val;
    } entry_t;

    entry_t           ent_q [ENTRIES];
    entry_t           ent_d [ENTRIES];
    entry_t           woken [ENTRIES+1];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] widx;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             issue_fire;
    logic             disp_fire;

    function automatic entry_t wake(
        input entry_t            e,
        input logic              act,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] val
    );
        entry_t r;
        r = e;
        if (act && r.valid && !r.rs1_rdy && r.rs1_tag == tag) begin
            r.rs1_rdy = 1'b1;
            r.rs1_val = val;
        end
        if (act && r.valid && !r.rs2_rdy && r.rs2_tag == tag) begin
            r.rs2_rdy = 1'b1;
            r.rs2_val = val;
        end
        return r;
    endfunction

    // Oldest-first select works on registered state only.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
    end

    assign issue_valid     = found;
    assign issue_payload   = ent_q[sel].payload;
    assign issue_rd        = ent_q[sel].rd;
    assign issue_rs1_value = ent_q[sel].rs1_val;
    assign issue_rs2_value = ent_q[sel].rs2_val;
    assign occupancy       = count_q;
    assign dispatch_ready  = (count_q < CNT_W'(ENTRIES));

    always_comb begin
        issue_fire = found && issue_accept;
        disp_fire  = dispatch_valid && dispatch_ready;
        widx       = count_q - CNT_W'(issue_fire);
        count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

        new_ent.valid   = 1'b1;
        new_ent.payload = dispatch_payload;
        new_ent.rd      = dispatch_rd;
        new_ent.rs1_tag = dispatch_rs1;
        new_ent.rs1_rdy = dispatch_rs1_ready;
        new_ent.rs1_val = dispatch_rs1_value;
        new_ent.rs2_tag = dispatch_rs2;
        new_ent.rs2_rdy = dispatch_rs2_ready;
        new_ent.rs2_val = dispatch_rs2_value;
        new_ent = wake(new_ent, wakeup_active, wakeup_tag, wakeup_value);

        // Extra empty slot at the top feeds the shift on issue.
        woken[ENTRIES] = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            woken[i] = wake(ent_q[i], wakeup_active, wakeup_tag, wakeup_value);
        end

        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_fire && IDX_W'(i) >= sel) begin
                ent_d[i] = woken[i+1];
            end else begin
                ent_d[i] = woken[i];
            end
            if (disp_fire && CNT_W'(i) == widx) begin
                ent_d[i] = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized + directed bench for reservation_station with a queue-based
// reference model and an issue scoreboard.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [31:0] dispatch_payload;
    logic [5:0]  dispatch_rd;
    logic [5:0]  dispatch_rs1;
    logic        dispatch_rs1_ready;
    logic [31:0] dispatch_rs1_value;
    logic [5:0]  dispatch_rs2;
    logic        dispatch_rs2_ready;
    logic [31:0] dispatch_rs2_value;
    logic        wakeup_active;
    logic [5:0]  wakeup_tag;
    logic [31:0] wakeup_value;
    logic        issue_valid;
    logic        issue_accept;
    logic [31:0] issue_payload;
    logic [5:0]  issue_rd;
    logic [31:0] issue_rs1_value;
    logic [31:0] issue_rs2_value;
    logic [4:0]  occupancy;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_payload(dispatch_payload), .dispatch_rd(dispatch_rd),
        .dispatch_rs1(dispatch_rs1), .dispatch_rs1_ready(dispatch_rs1_ready),
        .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2(dispatch_rs2),
        .dispatch_rs2_ready(dispatch_rs2_ready), .dispatch_rs2_value(dispatch_rs2_value),
        .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .issue_valid(issue_valid), .issue_accept(issue_accept),
        .issue_payload(issue_payload), .issue_rd(issue_rd),
        .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
        .occupancy(occupancy)
    );

    typedef struct packed {
        logic [31:0] pl;
        logic [5:0]  rd;
        logic [5:0]  t1;
        logic        r1;
        logic [31:0] v1;
        logic [5:0]  t2;
        logic        r2;
        logic [31:0] v2;
    } ment_t;

    typedef struct packed {
        logic        rst;
        logic        dv;
        logic        acc;
        logic        wa;
        logic [5:0]  wt;
        logic [31:0] wv;
        ment_t       e;
    } stim_t;

    ment_t        mq[$];
    logic [127:0] expq[$];
    int           tests = 0;
    int           fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int msel();
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic logic [127:0] pk(input ment_t e);
        return {e.pl, 26'b0, e.rd, e.v1, e.v2};
    endfunction

    function automatic ment_t mwake(input ment_t e, input logic wa,
                                    input logic [5:0] t, input logic [31:0] v);
        ment_t r;
        r = e;
        if (wa && !r.r1 && r.t1 == t) begin r.r1 = 1'b1; r.v1 = v; end
        if (wa && !r.r2 && r.t2 == t) begin r.r2 = 1'b1; r.v2 = v; end
        return r;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t dsp(input logic [5:0] rd, input logic [5:0] t1,
                                  input logic r1, input logic [31:0] v1,
                                  input logic [5:0] t2, input logic r2,
                                  input logic [31:0] v2);
        stim_t s;
        s = '0;
        s.dv = 1'b1;
        s.e.pl = $urandom;
        s.e.rd = rd;
        s.e.t1 = t1; s.e.r1 = r1; s.e.v1 = v1;
        s.e.t2 = t2; s.e.r2 = r2; s.e.v2 = v2;
        return s;
    endfunction

    // One cycle: called 1 time unit after a rising edge, returns likewise.
    task automatic step(input stim_t s);
        int sel;
        int n;
        chk("occupancy", 128'(occupancy), 128'(mq.size()));
        chk("issue_valid", 128'(issue_valid), 128'(msel() >= 0));
        chk("dispatch_ready", 128'(dispatch_ready), 128'(mq.size() < 16));
        reset              = s.rst;
        dispatch_valid     = s.dv;
        dispatch_payload   = s.e.pl;
        dispatch_rd        = s.e.rd;
        dispatch_rs1       = s.e.t1;
        dispatch_rs1_ready = s.e.r1;
        dispatch_rs1_value = s.e.v1;
        dispatch_rs2       = s.e.t2;
        dispatch_rs2_ready = s.e.r2;
        dispatch_rs2_value = s.e.v2;
        wakeup_active      = s.wa;
        wakeup_tag         = s.wt;
        wakeup_value       = s.wv;
        issue_accept       = s.acc;
        sel = msel();
        if (!s.rst && s.acc && sel >= 0) expq.push_back(pk(mq[sel]));
        @(posedge clk);
        if (s.rst) begin
            mq.delete();
        end else begin
            n = mq.size();
            foreach (mq[i]) mq[i] = mwake(mq[i], s.wa, s.wt, s.wv);
            if (s.acc && sel >= 0) mq.delete(sel);
            if (s.dv && n < 16) mq.push_back(mwake(s.e, s.wa, s.wt, s.wv));
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && issue_valid === 1'b1 && issue_accept === 1'b1) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL issue: unexpected issue rd=%0d, none expected", issue_rd);
            end else begin
                chk("issue", {issue_payload, 26'b0, issue_rd, issue_rs1_value, issue_rs2_value},
                    expq.pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        reset = 1'b1;
        dispatch_valid = 0; dispatch_payload = 0; dispatch_rd = 0;
        dispatch_rs1 = 0; dispatch_rs1_ready = 0; dispatch_rs1_value = 0;
        dispatch_rs2 = 0; dispatch_rs2_ready = 0; dispatch_rs2_value = 0;
        wakeup_active = 0; wakeup_tag = 0; wakeup_value = 0; issue_accept = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_occ", 128'(occupancy), 128'(0));
        chk("reset_ready", 128'(dispatch_ready), 128'(1));

        // Simple ready dispatch and issue
        step(dsp(6'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd9));
        chk("t1_rd", 128'(issue_rd), 128'(5));
        chk("t1_vals", {96'b0, issue_rs1_value}, 128'(7));
        s = idle(); s.acc = 1'b1;
        step(s);
        chk("t1_occ", 128'(occupancy), 128'(0));

        // Younger ready entry bypasses older blocked one
        step(dsp(6'd1, 6'd3, 1'b1, 32'd1, 6'd12, 1'b0, 32'd0));
        step(dsp(6'd2, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2));
        s = idle(); s.acc = 1'b1;
        step(s);
        s = idle(); s.acc = 1'b1; s.wa = 1'b1; s.wt = 6'd12; s.wv = 32'd456;
        step(s);
        chk("t2_rs2", 128'(issue_rs2_value), 128'(456));
        s = idle(); s.acc = 1'b1;
        step(s);

        // Dispatch-time wakeup bypass on both sources
        s = dsp(6'd3, 6'd20, 1'b0, 32'd0, 6'd20, 1'b0, 32'd0);
        s.wa = 1'b1; s.wt = 6'd20; s.wv = 32'd33;
        step(s);
        chk("t3_valid", 128'(issue_valid), 128'(1));
        chk("t3_vals", {64'b0, issue_rs1_value, issue_rs2_value}, {64'b0, 32'd33, 32'd33});
        s = idle(); s.acc = 1'b1;
        step(s);

        // Fill to capacity, drop extra, remove middle entry, drain in order
        for (int i = 0; i < 16; i++)
            step(dsp(6'(i), 6'(40 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'(i)));
        chk("t4_full_ready", 128'(dispatch_ready), 128'(0));
        chk("t4_full_occ", 128'(occupancy), 128'(16));
        step(dsp(6'd63, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1));
        s = idle(); s.wa = 1'b1; s.wt = 6'd43; s.wv = 32'd99;
        step(s);
        s = idle(); s.acc = 1'b1;
        step(s);
        chk("t4_occ15", 128'(occupancy), 128'(15));
        for (int i = 0; i < 16; i++) begin
            s = idle(); s.acc = 1'b1; s.wa = 1'b1; s.wt = 6'(40 + i); s.wv = 32'(1000 + i);
            step(s);
        end
        s = idle(); s.acc = 1'b1;
        for (int i = 0; i < 3; i++) step(s);

        // Accept + dispatch together keep occupancy, new entry lands last
        s = idle(); s.rst = 1'b1;
        step(s);
        step(dsp(6'd10, 6'd50, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1));
        step(dsp(6'd11, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd3));
        step(dsp(6'd12, 6'd52, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4));
        step(dsp(6'd13, 6'd53, 1'b0, 32'd0, 6'd0, 1'b1, 32'd5));
        s = dsp(6'd14, 6'd60, 1'b0, 32'd0, 6'd0, 1'b1, 32'd6);
        s.acc = 1'b1;
        step(s);
        chk("t5_occ", 128'(occupancy), 128'(4));
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.wa = 1'b1;
            s.wt = (i == 0) ? 6'd50 : (i == 1) ? 6'd52 : (i == 2) ? 6'd53 : 6'd60;
            s.wv = 32'(200 + i);
            step(s);
        end
        s = idle(); s.acc = 1'b1;
        for (int i = 0; i < 5; i++) step(s);

        // Reset discards pending entries
        for (int i = 0; i < 6; i++)
            step(dsp(6'(20 + i), 6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0));
        s = idle(); s.rst = 1'b1;
        step(s);
        chk("t6_occ", 128'(occupancy), 128'(0));
        s = idle(); s.acc = 1'b1; s.wa = 1'b1; s.wt = 6'd30; s.wv = 32'd5;
        step(s);
        chk("t6_valid", 128'(issue_valid), 128'(0));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s = dsp(6'($urandom), 6'($urandom_range(0, 15)), 1'($urandom % 2), $urandom,
                    6'($urandom_range(0, 15)), 1'($urandom % 2), $urandom);
            s.dv  = ($urandom % 4) != 0;
            s.rst = ($urandom_range(0, 299) == 0);
            s.wa  = $urandom % 2;
            s.wt  = 6'($urandom_range(0, 15));
            s.wv  = $urandom;
            s.acc = ($urandom % 4) != 0;
            step(s);
        end

        step(idle());
        @(negedge clk);
        chk("sb_empty", 128'(expq.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
